// File: rtl/retire_trace_buffer.sv
// rtl/retire_trace_buffer.sv - write-back retirement monitor with buffered trace records
// Optional feature macro: TRACE_NOP_RECORD_EN (push OTHER records for branches/NOPs).
module retire_trace_buffer #(
  parameter int DATA_W      = 16,
  parameter int REG_AW      = 4,
  parameter int DEPTH       = 16,
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ret_valid,
  input  logic [DATA_W-1:0] ret_pc,
  input  logic              ret_regwrite,
  input  logic [REG_AW-1:0] ret_reg,
  input  logic [DATA_W-1:0] ret_wdata,
  input  logic              ret_memread,
  input  logic              ret_memwrite,
  input  logic [DATA_W-1:0] ret_addr,
  input  logic [DATA_W-1:0] ret_mdata,
  input  logic              ret_halt,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [2:0]        rec_kind,
  output logic [CNT_W-1:0]  rec_inum,
  output logic [DATA_W-1:0] rec_pc,
  output logic [DATA_W-1:0] rec_addr,
  output logic [DATA_W-1:0] rec_val,
  output logic [REG_AW-1:0] rec_reg,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  inst_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic              overflow,
  output logic              halted,
  output logic              timeout,
  output logic              done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int REC_W = 3 + CNT_W + 3 * DATA_W + REG_AW;

  localparam logic [2:0] K_OTHER = 3'd0;
  localparam logic [2:0] K_REG   = 3'd1;
  localparam logic [2:0] K_LOAD  = 3'd2;
  localparam logic [2:0] K_STORE = 3'd3;
  localparam logic [2:0] K_HALT  = 3'd4;

  typedef enum logic [1:0] {
    S_RUN,
    S_HALT_PEND,
    S_HALTED,
    S_TIMEOUT
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [REC_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_occ;
  logic [CNT_W-1:0]  r_cycle;
  logic [CNT_W-1:0]  r_inst;
  logic [CNT_W-1:0]  r_drop;
  logic              r_overflow;
  logic [REC_W-1:0]  r_pend;

  logic [2:0]        w_kind;
  logic [REG_AW-1:0] w_reg;
  logic [DATA_W-1:0] w_addr;
  logic [DATA_W-1:0] w_val;
  logic [REC_W-1:0]  w_rec;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_slot;
  logic              w_run_ret;
  logic              w_want;
  logic              w_push;
  logic [REC_W-1:0]  w_push_data;
  logic              w_drop;
  logic              w_pend_load;

  always_comb begin
    w_kind = K_OTHER;
    w_reg  = '0;
    w_addr = '0;
    w_val  = '0;
    if (ret_halt) begin
      w_kind = K_HALT;
    end else if (ret_regwrite) begin
      w_reg = ret_reg;
      w_val = ret_wdata;
      if (ret_memread) begin
        w_kind = K_LOAD;
        w_addr = ret_addr;
      end else begin
        w_kind = K_REG;
      end
    end else if (ret_memwrite) begin
      w_kind = K_STORE;
      w_addr = ret_addr;
      w_val  = ret_mdata;
    end
  end

  assign w_rec     = {w_kind, r_inst, ret_pc, w_reg, w_addr, w_val};
  assign w_full    = (r_occ == (PTR_W+1)'(DEPTH));
  assign w_empty   = (r_occ == '0);
  assign w_pop     = !w_empty && rec_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_slot    = !w_full || w_pop;
  assign w_run_ret = (r_state == S_RUN) && ret_valid;

`ifdef TRACE_NOP_RECORD_EN
  assign w_want = w_run_ret;
`else
  assign w_want = w_run_ret && (w_kind != K_OTHER);
`endif

  always_comb begin
    w_state_nx  = r_state;
    w_push      = 1'b0;
    w_push_data = w_rec;
    w_drop      = 1'b0;
    w_pend_load = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_want) begin
          if (w_slot)                w_push      = 1'b1;
          else if (w_kind == K_HALT) w_pend_load = 1'b1;
          else                       w_drop      = 1'b1;
        end
        if (w_run_ret && (w_kind == K_HALT)) begin
          w_state_nx = w_slot ? S_HALTED : S_HALT_PEND;
        end else if (r_cycle == CNT_W'(CYCLE_LIMIT - 1)) begin
          w_state_nx = S_TIMEOUT;
        end
      end
      S_HALT_PEND: begin
        w_push_data = r_pend;
        if (w_slot) begin
          w_push     = 1'b1;
          w_state_nx = S_HALTED;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_RUN;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_cycle    <= '0;
      r_inst     <= '0;
      r_drop     <= '0;
      r_overflow <= 1'b0;
      r_pend     <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: ;
      endcase
      if (r_state == S_RUN) begin
        r_cycle <= r_cycle + 1'b1;
        if (ret_valid) r_inst <= r_inst + 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop != '1) r_drop <= r_drop + 1'b1;
      end
      if (w_pend_load) r_pend <= w_rec;
    end
  end

  // Storage needs no reset: pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  assign rec_valid = !w_empty;
  assign {rec_kind, rec_inum, rec_pc, rec_reg, rec_addr, rec_val} =
    rec_valid ? r_mem[r_rd_ptr] : '0;

  assign cycle_count = r_cycle;
  assign inst_count  = r_inst;
  assign drop_count  = r_drop;
  assign overflow    = r_overflow;
  assign halted      = (r_state == S_HALTED);
  assign timeout     = (r_state == S_TIMEOUT);
  assign done        = ((r_state == S_HALTED) || (r_state == S_TIMEOUT)) && w_empty;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// tb/tb_retire_trace_buffer.sv - scoreboard bench for retire_trace_buffer (DEPTH 4, limit 50)
module tb_retire_trace_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ret_valid = 1'b0;
  logic [15:0] ret_pc = '0;
  logic        ret_regwrite = 1'b0;
  logic [3:0]  ret_reg = '0;
  logic [15:0] ret_wdata = '0;
  logic        ret_memread = 1'b0;
  logic        ret_memwrite = 1'b0;
  logic [15:0] ret_addr = '0;
  logic [15:0] ret_mdata = '0;
  logic        ret_halt = 1'b0;
  logic        rec_valid;
  logic        rec_ready = 1'b0;
  logic [2:0]  rec_kind;
  logic [31:0] rec_inum;
  logic [15:0] rec_pc, rec_addr, rec_val;
  logic [3:0]  rec_reg;
  logic [31:0] cycle_count, inst_count, drop_count;
  logic        overflow, halted, timeout, done;

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] inum;
    logic [15:0] pc;
    logic [3:0]  rg;
    logic [15:0] addr;
    logic [15:0] val;
  } rec_t;

  rec_t exp_q[$];
  rec_t m_exp;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  retire_trace_buffer #(
    .DATA_W(16), .REG_AW(4), .DEPTH(4), .CNT_W(32), .CYCLE_LIMIT(50)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_regwrite(ret_regwrite),
    .ret_reg(ret_reg), .ret_wdata(ret_wdata), .ret_memread(ret_memread),
    .ret_memwrite(ret_memwrite), .ret_addr(ret_addr), .ret_mdata(ret_mdata),
    .ret_halt(ret_halt),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_kind(rec_kind),
    .rec_inum(rec_inum), .rec_pc(rec_pc), .rec_addr(rec_addr), .rec_val(rec_val),
    .rec_reg(rec_reg), .cycle_count(cycle_count), .inst_count(inst_count),
    .drop_count(drop_count), .overflow(overflow), .halted(halted),
    .timeout(timeout), .done(done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_rec(input logic [2:0] k, input logic [31:0] inum, input logic [15:0] pc,
                            input logic [3:0] rg, input logic [15:0] addr, input logic [15:0] val);
    rec_t r;
    r.kind = k; r.inum = inum; r.pc = pc; r.rg = rg; r.addr = addr; r.val = val;
    exp_q.push_back(r);
  endtask

  // Head is compared on the falling edge before the rising edge that pops it.
  always @(negedge clk) begin
    if (rst_n && rec_valid && rec_ready) begin
      if (exp_q.size() == 0) begin
        check("rec_unexpected", 64'(rec_valid), 64'd0);
      end else begin
        m_exp = exp_q.pop_front();
        check("rec_kind", 64'(rec_kind), 64'(m_exp.kind));
        check("rec_inum", 64'(rec_inum), 64'(m_exp.inum));
        check("rec_pc",   64'(rec_pc),   64'(m_exp.pc));
        check("rec_reg",  64'(rec_reg),  64'(m_exp.rg));
        check("rec_addr", 64'(rec_addr), 64'(m_exp.addr));
        check("rec_val",  64'(rec_val),  64'(m_exp.val));
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic retire(input logic rw, input logic mr, input logic mw, input logic hlt,
                        input logic [15:0] pc, input logic [3:0] rg, input logic [15:0] wd,
                        input logic [15:0] ad, input logic [15:0] md);
    ret_valid = 1'b1; ret_regwrite = rw; ret_memread = mr; ret_memwrite = mw; ret_halt = hlt;
    ret_pc = pc; ret_reg = rg; ret_wdata = wd; ret_addr = ad; ret_mdata = md;
    cycle();
    ret_valid = 1'b0; ret_regwrite = 1'b0; ret_memread = 1'b0; ret_memwrite = 1'b0;
    ret_halt = 1'b0; ret_pc = '0; ret_reg = '0; ret_wdata = '0; ret_addr = '0; ret_mdata = '0;
  endtask

  task automatic do_reg(input logic [15:0] pc, input logic [3:0] rg, input logic [15:0] wd);
    retire(1'b1, 1'b0, 1'b0, 1'b0, pc, rg, wd, 16'h0, 16'h0);
  endtask

  initial begin
    do_reset();
    check("rst_rec_valid", 64'(rec_valid), 64'd0);
    check("rst_rec_kind",  64'(rec_kind),  64'd0);
    check("rst_cycle",     64'(cycle_count), 64'd0);
    check("rst_inst",      64'(inst_count),  64'd0);
    check("rst_drop",      64'(drop_count),  64'd0);
    check("rst_status",    64'({overflow, halted, timeout, done}), 64'd0);

    // REG then STORE with a ready consumer
    rec_ready = 1'b1;
    expect_rec(3'd1, 32'd0, 16'h0000, 4'd3, 16'h0000, 16'h0005);
    expect_rec(3'd3, 32'd1, 16'h0002, 4'd0, 16'h0010, 16'hBEEF);
    do_reg(16'h0000, 4'd3, 16'h0005);
    retire(1'b0, 1'b0, 1'b1, 1'b0, 16'h0002, 4'd0, 16'h0, 16'h0010, 16'hBEEF);
    repeat (3) cycle();
    check("a_inst",  64'(inst_count),  64'd2);
    check("a_cycle", 64'(cycle_count), 64'd5);
    check("a_q_empty", 64'(exp_q.size()), 64'd0);

    // Overflow: six REG retirements into a 4-deep FIFO with no consumer
    do_reset();
    rec_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) expect_rec(3'd1, 32'(i), 16'(2 * i), 4'(i), 16'h0, 16'(16'h100 + i));
      do_reg(16'(2 * i), 4'(i), 16'(16'h100 + i));
    end
    check("b_drop",     64'(drop_count), 64'd2);
    check("b_overflow", 64'(overflow),   64'd1);
    check("b_inst",     64'(inst_count), 64'd6);
    check("b_valid",    64'(rec_valid),  64'd1);
    cycle();
    check("b_head_stable", 64'(rec_inum), 64'd0);
    // Full FIFO with a simultaneous pop still accepts the push
    expect_rec(3'd1, 32'd6, 16'h000C, 4'd6, 16'h0, 16'h0106);
    rec_ready = 1'b1;
    do_reg(16'h000C, 4'd6, 16'h0106);
    repeat (6) cycle();
    check("b_drop_after", 64'(drop_count), 64'd2);
    check("b_inst_after", 64'(inst_count), 64'd7);
    check("b_q_empty", 64'(exp_q.size()), 64'd0);

    // Pending halt behind a full FIFO
    do_reset();
    rec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_rec(3'd1, 32'(i), 16'(2 * i), 4'(i), 16'h0, 16'(16'h200 + i));
      do_reg(16'(2 * i), 4'(i), 16'(16'h200 + i));
    end
    expect_rec(3'd4, 32'd4, 16'h0008, 4'd0, 16'h0, 16'h0);
    retire(1'b0, 1'b0, 1'b0, 1'b1, 16'h0008, 4'd0, 16'h0, 16'h0, 16'h0);
    check("c_pend_halted", 64'(halted), 64'd0);
    check("c_pend_done",   64'(done),   64'd0);
    check("c_inst",        64'(inst_count), 64'd5);
    do_reg(16'h000A, 4'd1, 16'h0055);
    check("c_ignored_inst", 64'(inst_count),  64'd5);
    check("c_frozen_cycle", 64'(cycle_count), 64'd5);
    rec_ready = 1'b1;
    cycle();
    check("c_halted",       64'(halted), 64'd1);
    check("c_not_done_yet", 64'(done),   64'd0);
    repeat (5) cycle();
    check("c_done",  64'(done), 64'd1);
    check("c_cycle", 64'(cycle_count), 64'd5);
    check("c_q_empty", 64'(exp_q.size()), 64'd0);

    // Timeout after CYCLE_LIMIT cycles
    do_reset();
    rec_ready = 1'b1;
    expect_rec(3'd1, 32'd0, 16'h0040, 4'd2, 16'h0, 16'h0077);
    do_reg(16'h0040, 4'd2, 16'h0077);
    repeat (48) cycle();
    check("d_no_timeout_49", 64'(timeout), 64'd0);
    check("d_cycle_49", 64'(cycle_count), 64'd49);
    cycle();
    check("d_timeout", 64'(timeout), 64'd1);
    check("d_cycle_50", 64'(cycle_count), 64'd50);
    check("d_done", 64'(done), 64'd1);
    check("d_halted", 64'(halted), 64'd0);
    do_reg(16'h0042, 4'd3, 16'h0011);
    repeat (2) cycle();
    check("d_inst_frozen",  64'(inst_count),  64'd1);
    check("d_cycle_frozen", 64'(cycle_count), 64'd50);
    check("d_q_empty", 64'(exp_q.size()), 64'd0);

    // Halt retiring on the limit cycle wins over timeout
    do_reset();
    rec_ready = 1'b1;
    repeat (49) cycle();
    check("e_cycle_49", 64'(cycle_count), 64'd49);
    expect_rec(3'd4, 32'd0, 16'h0060, 4'd0, 16'h0, 16'h0);
    retire(1'b0, 1'b0, 1'b0, 1'b1, 16'h0060, 4'd0, 16'h0, 16'h0, 16'h0);
    check("e_halted",  64'(halted),  64'd1);
    check("e_timeout", 64'(timeout), 64'd0);
    check("e_cycle",   64'(cycle_count), 64'd50);
    repeat (2) cycle();
    check("e_done", 64'(done), 64'd1);
    check("e_q_empty", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of operation discards buffered records
    do_reset();
    rec_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_reg(16'(i), 4'(i), 16'(i));
    check("f_valid_before", 64'(rec_valid), 64'd1);
    do_reset();
    check("f_valid", 64'(rec_valid), 64'd0);
    check("f_counters", 64'({cycle_count, inst_count}), 64'd0);
    check("f_drop", 64'(drop_count), 64'd0);
    check("f_status", 64'({overflow, halted, timeout, done}), 64'd0);
    rec_ready = 1'b1;
    expect_rec(3'd2, 32'd0, 16'h0030, 4'd7, 16'h0044, 16'h1234);
    retire(1'b1, 1'b1, 1'b0, 1'b0, 16'h0030, 4'd7, 16'h1234, 16'h0044, 16'h0);
    repeat (2) cycle();
    check("f_q_empty", 64'(exp_q.size()), 64'd0);

    // Branch without a write
    do_reset();
    rec_ready = 1'b1;
`ifdef TRACE_NOP_RECORD_EN
    expect_rec(3'd0, 32'd0, 16'h0020, 4'd0, 16'h0, 16'h0);
`endif
    expect_rec(3'd1, 32'd1, 16'h0022, 4'd5, 16'h0, 16'h0009);
    retire(1'b0, 1'b0, 1'b0, 1'b0, 16'h0020, 4'd0, 16'h0, 16'h0, 16'h0);
    do_reg(16'h0022, 4'd5, 16'h0009);
    repeat (3) cycle();
    check("g_inst", 64'(inst_count), 64'd2);
    check("g_drop", 64'(drop_count), 64'd0);
    check("g_q_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/retire_trace_buffer.md
# retire_trace_buffer

Synthesizable retirement monitor for the pipelined CPU. It samples the write-back stage each cycle and classifies every retiring instruction as register write, load, store, halt or other. Each instruction becomes a numbered trace record, and records are buffered in a parametrised FIFO that a consumer drains over a valid/ready handshake. The block also keeps cycle and instruction counters, detects halt and a cycle-limit timeout, and signals when the trace is fully drained. It sits beside `cpu`, fed from write-back pipeline registers, and replaces ad-hoc bench-side trace printing.

## Interface
Parameters:
- `DATA_W`, 16, width of PC, data and address fields
- `REG_AW`, 4, register index width
- `DEPTH`, 16, FIFO entries; power of two, ≥ 2
- `CNT_W`, 32, width of counters and `rec_inum`
- `CYCLE_LIMIT`, 100000, cycle count at which timeout is declared

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset: synchronous, active-low
- `ret_valid`  in  1  one instruction retires this cycle
- `ret_pc`  in  DATA_W  PC of the retiring instruction
- `ret_regwrite`  in  1  the instruction writes the register file
- `ret_reg`  in  REG_AW  destination register
- `ret_wdata`  in  DATA_W  register write data
- `ret_memread`, `ret_memwrite`  in  1 each  memory read / write
- `ret_addr`  in  DATA_W  memory address
- `ret_mdata`  in  DATA_W  store data
- `ret_halt`  in  1  the instruction is HLT
- `rec_valid`  out  1  a record is presented at the FIFO head
- `rec_ready`  in  1  the consumer accepts the head record
- `rec_kind`  out  3  record kind: 0 OTHER, 1 REG, 2 LOAD, 3 STORE, 4 HALT
- `rec_inum`  out  CNT_W  instruction number, starting at 0
- `rec_pc`, `rec_addr`, `rec_val`  out  DATA_W each  record payload
- `rec_reg`  out  REG_AW  destination register of the record
- `cycle_count`, `inst_count`, `drop_count`  out  CNT_W each  counters
- `overflow`  out  1  sticky: at least one record was dropped
- `halted`, `timeout`, `done`  out  1 each  status

## Operation
- State machine with states RUN, HALT_PEND, HALTED, TIMEOUT. Reset enters RUN.
- Classification uses this priority order:
  - `ret_halt` gives HALT.
  - Otherwise `ret_regwrite` gives LOAD if `ret_memread` is set, else REG.
  - Otherwise `ret_memwrite` gives STORE.
  - Otherwise the kind is OTHER.
- Payload fields per kind:
  - REG: `rec_val` = `ret_wdata`.
  - LOAD: `rec_val` = `ret_wdata`, `rec_addr` = `ret_addr`.
  - STORE: `rec_val` = `ret_mdata`, `rec_addr` = `ret_addr`.
  - Unused payload fields are 0.
- RUN state:
  - Each `ret_valid` cycle builds a record with `rec_inum` = current `inst_count`, then increments `inst_count` (modulo 2^CNT_W).
  - `cycle_count` increments every cycle.
- Push rule: a push succeeds when the FIFO is not full, or when it is full and a pop happens in the same cycle.
  - If a non-HALT push fails, the record is dropped, `drop_count` increments (saturating at all-ones) and `overflow` is set.
  - `inst_count` still increments on a drop, so the gap shows up in `rec_inum`.
- HALT record:
  - If the push succeeds, the state goes to HALTED.
  - If the FIFO is full with no pop, the record is held internally and the state goes to HALT_PEND. It is pushed on the first cycle a slot frees, then the state goes to HALTED.
- HALT_PEND, HALTED and TIMEOUT:
  - `ret_valid` is ignored.
  - `cycle_count` and `inst_count` are frozen.
  - Draining continues.
- TIMEOUT: entered from RUN when `cycle_count` reaches `CYCLE_LIMIT - 1` and no halt is retiring that cycle. A halt retiring in that same cycle takes precedence.
- Status outputs:
  - `halted` = 1 in HALTED.
  - `timeout` = 1 in TIMEOUT.
  - `done` = (HALTED or TIMEOUT) and FIFO empty.
- FIFO: circular buffer with wrap-around read/write pointers and a full/empty occupancy count. Pop happens when `rec_valid` && `rec_ready`.

## Timing
- Reset: all outputs are 0, the FIFO is emptied and the state is RUN. Asserting `rst_n` low mid-operation discards buffered records and any pending HALT.
- Latency: a record pushed at edge N is at the head with `rec_valid` = 1 after edge N when the FIFO was empty. There is no combinational input-to-output bypass.
- Head fields stay stable while `rec_valid` && !`rec_ready`.
- Counters update on the same edge as the retirement is sampled.
- Simultaneous push and pop:
  - On an empty FIFO, the pop is not possible, so only the push takes effect.
  - On a full FIFO, both take effect and the occupancy is unchanged.

## Configuration
- `TRACE_NOP_RECORD_EN` defined: OTHER records (branches, NOPs) are pushed like any other kind.
- Not defined: OTHER retirements increment `inst_count` but are never pushed and never count as drops.

## Test plan
- Reg and store records: retire ADD (r3 ← 0x0005, pc 0x0000) then SW (addr 0x0010, data 0xBEEF, pc 0x0002) with `rec_ready` = 1.
  - Expect REG inum 0, reg 3, val 0x0005.
  - Then STORE inum 1, addr 0x0010, val 0xBEEF.
  - `inst_count` = 2.
- Overflow: `DEPTH` = 4, `rec_ready` = 0, 6 REG retirements.
  - Expect 4 buffered with inum 0–3.
  - `drop_count` = 2, `overflow` = 1, `inst_count` = 6.
- Pending halt: FIFO full, HLT retires, then `rec_ready` is raised.
  - Expect HALT_PEND; HALT pushed on the first pop cycle.
  - `halted` = 1 after that cycle, and `done` = 1 once the FIFO is drained.
- Timeout: `CYCLE_LIMIT` = 50, no halt.
  - Expect `timeout` = 1 after 50 cycles, `cycle_count` frozen at 50.
  - Later retirements are ignored.
- Reset mid-operation: 3 buffered records, `rst_n` = 0 for one cycle.
  - Expect `rec_valid` = 0, all counters 0, state RUN.
- NOP handling: a BEQ retirement without a write.
  - With `TRACE_NOP_RECORD_EN`: an OTHER record is produced.
  - Without it: no record is produced and `inst_count` still increments.
